fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch front-end for the multi-cycle LoongArch core. It owns the fetch PC and drives the instruction SRAM port, which has a 1-cycle synchronous read.
- It captures each returned instruction, holds it, and presents it to decode with a valid/allowin handshake.
- It accepts branch/jump redirects from the execute side, cancels any wrong-path request, and flags misaligned fetch addresses (ADEF) without accessing SRAM.

Parameters:
- RESET_PC, 32'h1c00_0000, first fetch address after reset.
- NOP_INST, 32'h0340_0000 (andi r0,r0,0), instruction word presented when fs_adef=1.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- resetn  in  1  synchronous active-low reset.
- inst_sram_we  out  1  constant 0.
- inst_sram_addr  out  32  fetch address; always equals the fetch_pc register.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  read data; valid the cycle after an address is presented.
- br_taken  in  1  redirect request, valid for one cycle.
- br_target  in  32  redirect address, qualified by br_taken.
- ds_allowin  in  1  decode can accept the held instruction this cycle.
- fs_valid  out  1  fs_pc/fs_inst/fs_adef are valid.
- fs_pc  out  32  PC of the held instruction.
- fs_inst  out  32  held instruction word.
- fs_adef  out  1  held entry is a misaligned-fetch exception.

Behaviour:
- Reset (resetn=0 at a posedge):
  - state=S_IDLE, fetch_pc=RESET_PC.
  - fs_valid=0, fs_pc=0, fs_inst=0, fs_adef=0.
  - inst_sram_addr=RESET_PC.
  - Reset overrides everything, including a request in flight; stale rdata is never captured.
- State encoding (2 bits): S_IDLE, S_REQ, S_RESP, S_HOLD.
- S_IDLE:
  - Next state is S_REQ at the first posedge with resetn=1.
- S_REQ:
  - The address on inst_sram_addr is sampled by SRAM at the end of this cycle.
  - br_taken=1 → fetch_pc<=br_target, stay in S_REQ. Read data returned next cycle is ignored.
  - Otherwise, if fetch_pc[1:0]!=0 → S_HOLD with fs_valid<=1, fs_pc<=fetch_pc, fs_inst<=NOP_INST, fs_adef<=1. No SRAM capture.
  - Otherwise → S_RESP.
- S_RESP:
  - br_taken=1 → discard rdata, fetch_pc<=br_target, → S_REQ.
  - Otherwise capture fs_inst<=inst_sram_rdata, fs_pc<=fetch_pc, fs_adef<=0, fs_valid<=1, → S_HOLD.
- S_HOLD:
  - Outputs are stable until the handshake; fs_valid stays 1 while ds_allowin=0 (back-pressure with no limit).
  - br_taken=1, regardless of ds_allowin → fetch_pc<=br_target, fs_valid<=0, → S_REQ. If ds_allowin=1 in that same cycle, the held instruction counts as consumed; otherwise it is dropped.
  - ds_allowin=1 and br_taken=0 → fetch_pc<=fetch_pc+32'd4 (mod 2^32; 32'hffff_fffc wraps to 0), fs_valid<=0, → S_REQ.
- Timing and outputs:
  - Minimum latency from entering S_REQ to fs_valid=1 is 2 cycles.
  - Best-case throughput is one instruction per 3 cycles.
  - fs_pc/fs_inst/fs_adef keep their last values when fs_valid=0 and are don't-care to decode.
  - A br_target with bits[1:0]!=0 produces the ADEF path on the next S_REQ.
  - br_taken in S_IDLE is ignored.

Decomposition:
- Shared package (core_pkg): RESET_PC and NOP_INST defaults, the fetch state encoding, and the ADEF exception code constant (shared with the future CSR/exception stage).
- No sub-module: a single FSM plus datapath registers, target 150-220 lines of RTL.

Test Plan:
- Boot:
  - Stimulus: release resetn at edge E0; SRAM holds 0x02800421 at 0x1c00_0000; ds_allowin=1.
  - Response: addr=0x1c00_0000 through E1–E2; fs_valid=1 after E2 with fs_pc=0x1c00_0000, fs_inst=0x02800421; addr=0x1c00_0004 after E3.
- Back-pressure:
  - Stimulus: ds_allowin=0 for 10 cycles while in S_HOLD.
  - Response: fs_valid, fs_pc, fs_inst unchanged, no new address issued; on ds_allowin=1, the next fetch is fs_pc+4.
- Redirect in S_RESP:
  - Stimulus: br_taken=1, br_target=0x1c00_0100 during S_RESP of 0x1c00_0008.
  - Response: 0x1c00_0008 never appears on fs_pc; next fs_pc=0x1c00_0100.
- Redirect in S_HOLD with ds_allowin=0:
  - Stimulus: held 0x1c00_0010; br_taken=1 to 0x1c00_0040.
  - Response: fs_valid=0 next cycle; the next valid entry is 0x1c00_0040.
- Misaligned target:
  - Stimulus: br_target=0x1c00_0102.
  - Response: fs_valid=1, fs_adef=1, fs_inst=0x0340_0000, fs_pc=0x1c00_0102, reached from S_REQ in 1 cycle.
- Reset mid-fetch:
  - Stimulus: resetn=0 for 1 cycle in S_RESP.
  - Response: fs_valid=0, addr=RESET_PC; the boot sequence repeats and the in-flight data is discarded.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: boot PC, NOP word, fetch FSM encoding, exception codes
package core_pkg;

   localparam logic [31:0] CORE_RESET_PC = 32'h1c00_0000;
   localparam logic [31:0] CORE_NOP_INST = 32'h0340_0000;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   // Shared with the CSR/exception stage.
   localparam logic [5:0] ECODE_ADEF = 6'h08;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM: owns fetch PC, drives inst SRAM, holds one entry for decode
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CORE_RESET_PC,
   parameter logic [31:0] NOP_INST = CORE_NOP_INST
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ds_allowin,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adef
);

   logic [1:0]  state;
   logic [31:0] fetch_pc;

   assign inst_sram_we    = 1'b0;
   assign inst_sram_wdata = 32'd0;
   assign inst_sram_addr  = fetch_pc;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         fs_valid <= 1'b0;
         fs_pc    <= 32'd0;
         fs_inst  <= 32'd0;
         fs_adef  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               // A redirect here re-issues at once; the read launched this cycle is never captured.
               if (br_taken) begin
                  fetch_pc <= br_target;
               end else if (is_misaligned(fetch_pc)) begin
                  fs_valid <= 1'b1;
                  fs_pc    <= fetch_pc;
                  fs_inst  <= NOP_INST;
                  fs_adef  <= 1'b1;
                  state    <= S_HOLD;
               end else begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (br_taken) begin
                  fetch_pc <= br_target;
                  state    <= S_REQ;
               end else begin
                  fs_valid <= 1'b1;
                  fs_pc    <= fetch_pc;
                  fs_inst  <= inst_sram_rdata;
                  fs_adef  <= 1'b0;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (br_taken) begin
                  fetch_pc <= br_target;
                  fs_valid <= 1'b0;
                  state    <= S_REQ;
               end else if (ds_allowin) begin
                  fetch_pc <= fetch_pc + 32'd4;
                  fs_valid <= 1'b0;
                  state    <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
